// File: rtl/gray_step_arbiter.sv
// -----------------------------------------------------------------------------
// gray_step_arbiter
//
// Shares one enable-stepped 3-bit Gray counter between two requesters. Each
// requester asks for N counter steps. The arbiter grants round-robin and holds
// the counter enable high for exactly N cycles. It then returns the final Gray
// value, a wrap flag and a one-cycle acknowledge.
//
// Ports
//   Clk          clock, all state updates on the rising edge
//   Reset        synchronous, active-high reset
//   Req0/Req1    level job requests, held until the matching Ack
//   Steps0/1     requested step counts, sampled at grant
//   Ack0/Ack1    one-cycle job-complete pulses
//   Grant        one-hot current owner ({Req1,Req0} order), 00 when idle
//   Busy         high whenever the FSM is outside IDLE
//   Result       Gray value captured at job end, held until the next capture
//   Wrap         set when the last job passed 100 -> 000, held with Result
//   Cnt_En       enable to the shared counter (decode of the RUN state only)
//   Cnt_Reset    reset to the shared counter (passthrough of Reset)
//   Cnt_Output   registered output of the shared counter
// -----------------------------------------------------------------------------
module gray_step_arbiter #(
  parameter int STEP_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0,
  input  logic [STEP_W-1:0] Steps0,
  input  logic              Req1,
  input  logic [STEP_W-1:0] Steps1,
  output logic              Ack0,
  output logic              Ack1,
  output logic [1:0]        Grant,
  output logic              Busy,
  output logic [2:0]        Result,
  output logic              Wrap,
  output logic              Cnt_En,
  output logic              Cnt_Reset,
  input  logic [2:0]        Cnt_Output
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Last code before the counter rolls back to 000.
  localparam logic [2:0] GRAY_TOP = 3'b100;

  state_t            state, state_nxt;
  logic [1:0]        grant_r, grant_nxt;
  logic [STEP_W-1:0] remaining, remaining_nxt;
  logic              wrap_int, wrap_int_nxt;
  // ptr = 0 favours requester 0, ptr = 1 favours requester 1.
  logic              ptr, ptr_nxt;
  logic [2:0]        result_r, result_nxt;
  logic              wrap_r, wrap_nxt;

  logic [1:0]        sel;
  logic [STEP_W-1:0] steps_sel;

  // Round-robin pick: a lone request always wins, a tie goes to the
  // pointer-favoured requester.
  function automatic logic [1:0] arbitrate(input logic r0, input logic r1,
                                           input logic fav1);
    logic [1:0] pick;
    if (r0 && r1) begin
      pick = fav1 ? 2'b10 : 2'b01;
    end else begin
      pick = {r1, r0};
    end
    return pick;
  endfunction

  assign sel       = arbitrate(Req0, Req1, ptr);
  assign steps_sel = sel[1] ? Steps1 : Steps0;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      grant_r   <= 2'b00;
      remaining <= '0;
      wrap_int  <= 1'b0;
      ptr       <= 1'b0;
      result_r  <= 3'b000;
      wrap_r    <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant_r   <= grant_nxt;
      remaining <= remaining_nxt;
      wrap_int  <= wrap_int_nxt;
      ptr       <= ptr_nxt;
      result_r  <= result_nxt;
      wrap_r    <= wrap_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant_r;
    remaining_nxt = remaining;
    wrap_int_nxt  = wrap_int;
    ptr_nxt       = ptr;
    result_nxt    = result_r;
    wrap_nxt      = wrap_r;

    case (state)
      IDLE: begin
        if (sel != 2'b00) begin
          grant_nxt     = sel;
          remaining_nxt = steps_sel;
          wrap_int_nxt  = 1'b0;
          // After serving requester 0, favour requester 1, and vice versa.
          ptr_nxt       = sel[0];
          if (steps_sel == '0) begin
            // Zero-step job: report the counter as it stands, no enable pulse.
            state_nxt  = DONE;
            result_nxt = Cnt_Output;
            wrap_nxt   = 1'b0;
          end else begin
            state_nxt = RUN;
          end
        end
      end

      RUN: begin
        remaining_nxt = remaining - 1'b1;
        // Seeing 100 during an enabled cycle means this edge rolls to 000.
        if (Cnt_Output == GRAY_TOP) begin
          wrap_int_nxt = 1'b1;
        end
        // The <= also covers an impossible 0, so RUN can never spin.
        if (remaining <= 1) begin
          state_nxt = SETTLE;
        end
      end

      SETTLE: begin
        // The counter has registered the final step by now.
        result_nxt = Cnt_Output;
        wrap_nxt   = wrap_int;
        state_nxt  = DONE;
      end

      DONE: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end

      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  // Outputs are pure decodes of registered state, so there is no path from
  // Req to Cnt_En or Ack.
  assign Cnt_En    = (state == RUN);
  assign Busy      = (state != IDLE);
  assign Ack0      = (state == DONE) && grant_r[0];
  assign Ack1      = (state == DONE) && grant_r[1];
  assign Grant     = grant_r;
  assign Result    = result_r;
  assign Wrap      = wrap_r;
  assign Cnt_Reset = Reset;

endmodule

// File: tb/tb_gray_step_arbiter.sv
module tb_gray_step_arbiter;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Req0, Req1;
  logic [3:0] Steps0, Steps1;
  logic       Ack0, Ack1;
  logic [1:0] Grant;
  logic       Busy;
  logic [2:0] Result;
  logic       Wrap;
  logic       Cnt_En, Cnt_Reset;
  logic [2:0] Cnt_Output;

  int checks = 0;
  int errors = 0;

  gray_step_arbiter #(.STEP_W(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .Steps0(Steps0), .Req1(Req1), .Steps1(Steps1),
    .Ack0(Ack0), .Ack1(Ack1), .Grant(Grant), .Busy(Busy),
    .Result(Result), .Wrap(Wrap),
    .Cnt_En(Cnt_En), .Cnt_Reset(Cnt_Reset), .Cnt_Output(Cnt_Output)
  );

  always #5 Clk = ~Clk;

  // Shared Gray counter the arbiter drives.
  function automatic logic [2:0] gray_next(input logic [2:0] g);
    case (g)
      3'b000:  return 3'b001;
      3'b001:  return 3'b011;
      3'b011:  return 3'b010;
      3'b010:  return 3'b110;
      3'b110:  return 3'b111;
      3'b111:  return 3'b101;
      3'b101:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  always_ff @(posedge Clk) begin
    if (Cnt_Reset)   Cnt_Output <= 3'b000;
    else if (Cnt_En) Cnt_Output <= gray_next(Cnt_Output);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; Req0 = 1'b0; Req1 = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Waits (bounded) for the Ack of requester sel; returns at the Ack negedge.
  task automatic wait_ack(input string name, input int sel);
    bit seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge Clk);
      if ((sel == 0 && Ack0) || (sel == 1 && Ack1)) seen = 1;
    end
    chk({name, " ack seen"}, seen, 1);
  endtask

  // Issues one job from an IDLE negedge and checks it end to end, finishing
  // on the IDLE negedge that follows the Ack.
  task automatic run_and_check(input string name, input int sel, input logic [3:0] steps,
                               input bit keep, input logic [2:0] exp_res, input logic exp_wrap);
    logic [1:0] exp_g = (sel == 0) ? 2'b01 : 2'b10;
    int wait_n = 0, en_n = 0, lat = 0;
    bit granted = 0, done = 0, grant_ok = 1, other_ack = 0;
    logic [2:0] res = 3'bxxx;
    logic w = 1'bx;
    if (sel == 0) begin Req0 = 1'b1; Steps0 = steps; end
    else          begin Req1 = 1'b1; Steps1 = steps; end
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge Clk);
      if (!granted) begin
        wait_n++;
        if (Grant != 2'b00) granted = 1;
      end
      if (granted) begin
        if (Grant != exp_g || !Busy) grant_ok = 0;
        if (Cnt_En) en_n++;
        if ((sel == 0 && Ack1) || (sel == 1 && Ack0)) other_ack = 1;
        if ((sel == 0 && Ack0) || (sel == 1 && Ack1)) begin
          done = 1;
          res = Result;
          w = Wrap;
          if (!keep) begin
            if (sel == 0) Req0 = 1'b0; else Req1 = 1'b0;
          end
        end else begin
          lat++;
        end
      end
    end
    chk({name, " done"}, done, 1);
    chk({name, " grant delay"}, wait_n, 1);
    chk({name, " en cycles"}, en_n, steps);
    chk({name, " ack latency"}, lat, (steps == 0) ? 0 : steps + 1);
    chk({name, " result"}, res, exp_res);
    chk({name, " wrap"}, w, exp_wrap);
    chk({name, " grant held"}, grant_ok, 1);
    chk({name, " other ack"}, other_ack, 0);
    @(negedge Clk);
    chk({name, " idle grant"}, Grant, 2'b00);
    chk({name, " idle busy"}, Busy, 0);
  endtask

  typedef struct {
    int         sel;
    logic [3:0] steps;
    logic [2:0] exp_res;
    logic       exp_wrap;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int acks;
    bit got;
    Reset = 1'b1; Req0 = 1'b0; Req1 = 1'b0; Steps0 = 4'd0; Steps1 = 4'd0;

    // Each vector starts from reset, so the counter begins at 000.
    tbl[0] = '{0, 4'd3,  3'b010, 1'b0};
    tbl[1] = '{1, 4'd9,  3'b001, 1'b1};
    tbl[2] = '{0, 4'd0,  3'b000, 1'b0};
    tbl[3] = '{1, 4'd8,  3'b000, 1'b1};
    tbl[4] = '{0, 4'd7,  3'b100, 1'b0};
    tbl[5] = '{1, 4'd15, 3'b100, 1'b1};

    // Reset state
    @(negedge Clk);
    @(negedge Clk);
    chk("rst cnt_reset", Cnt_Reset, 1);
    chk("rst grant", Grant, 2'b00);
    chk("rst busy", Busy, 0);
    chk("rst acks", {Ack1, Ack0}, 2'b00);
    chk("rst result", Result, 3'b000);
    chk("rst wrap", Wrap, 0);
    chk("rst cnt_en", Cnt_En, 0);
    chk("rst counter", Cnt_Output, 3'b000);
    Reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_reset();
      run_and_check($sformatf("vec%0d", i), tbl[i].sel, tbl[i].steps, 1'b0,
                    tbl[i].exp_res, tbl[i].exp_wrap);
    end

    // Simultaneous requests: requester 0 first, then 1, then 0 favoured again.
    do_reset();
    Req0 = 1'b1; Steps0 = 4'd2; Req1 = 1'b1; Steps1 = 4'd1;
    @(negedge Clk);
    chk("both first grant", Grant, 2'b01);
    wait_ack("both r0", 0);
    chk("both r0 result", Result, 3'b011);
    Req0 = 1'b0;
    @(negedge Clk);
    chk("both idle gap", Grant, 2'b00);
    @(negedge Clk);
    chk("both second grant", Grant, 2'b10);
    wait_ack("both r1", 1);
    chk("both r1 result", Result, 3'b010);
    chk("both r1 wrap", Wrap, 0);
    Req1 = 1'b0;
    @(negedge Clk);
    Req0 = 1'b1; Req1 = 1'b1; Steps0 = 4'd1; Steps1 = 4'd1;
    @(negedge Clk);
    chk("again favour r0", Grant, 2'b01);
    wait_ack("again r0", 0);
    chk("again r0 result", Result, 3'b110);
    Req0 = 1'b0;
    wait_ack("again r1", 1);
    chk("again r1 result", Result, 3'b111);
    Req1 = 1'b0;
    @(negedge Clk);

    // Zero-step job with the counter parked at a non-zero value.
    run_and_check("zero mid", 0, 4'd0, 1'b0, 3'b111, 1'b0);

    // Reset during RUN cycle 4 aborts the job without an Ack.
    do_reset();
    Req0 = 1'b1; Steps0 = 4'd10;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge Clk);
      if (Grant != 2'b00) got = 1;
    end
    chk("abort granted", got, 1);
    repeat (3) @(negedge Clk);
    chk("abort run4 en", Cnt_En, 1);
    chk("abort run4 counter", Cnt_Output, 3'b010);
    Reset = 1'b1; Req0 = 1'b0;
    @(negedge Clk);
    chk("abort busy", Busy, 0);
    chk("abort grant", Grant, 2'b00);
    chk("abort counter", Cnt_Output, 3'b000);
    chk("abort cnt_en", Cnt_En, 0);
    Reset = 1'b0;
    acks = 0;
    repeat (20) begin
      @(negedge Clk);
      if (Ack0) acks++;
    end
    chk("abort no ack0", acks, 0);
    run_and_check("after abort", 1, 4'd1, 1'b0, 3'b001, 1'b0);

    // Req0 held through its Ack becomes a second job after one IDLE cycle.
    do_reset();
    run_and_check("held1", 0, 4'd1, 1'b1, 3'b001, 1'b0);
    run_and_check("held2", 0, 4'd1, 1'b0, 3'b011, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
